// File: rtl/adder_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin adder arbiter (adder_rr_arbiter).
package adder_arb_pkg;

    localparam int OPCOUNT_W = 16;
    localparam int MAX_REQ   = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } tag_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] id);
        onehot     = '0;
        onehot[id] = 1'b1;
    endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after the last granted index.
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         grant_idx
);

    logic found;
    int   cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        // Offsets 1..NUM_REQ so the last winner is searched last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (j == cand) && req[j]) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one external adder among NUM_REQ requesters.
// Optional saturating transfer counter enabled by macro ADDER_ARB_OPCOUNT_EN.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arb_en,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_cout,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout
`ifdef ADDER_ARB_OPCOUNT_EN
    ,
    output logic [OPCOUNT_W-1:0]     op_count
`endif
);

    localparam int DEPTH = 1 + ADD_LATENCY;

    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic               add_cin_q, add_cin_d;
    logic [2:0]         last_q, last_d;
    tag_t               tag_q [DEPTH];
    tag_t               tag_d [DEPTH];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
    logic               rsp_cout_q, rsp_cout_d;

    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] grant;
    logic [2:0]         grant_idx;
    logic               xfer;

    assign pick_req = (rst || !arb_en) ? '0 : req_valid;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req       (pick_req),
        .last      (last_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);

    always_comb begin
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        last_d      = last_q;
        tag_d[0]    = '0;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        if (xfer) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    add_a_d   = req_a[i*WIDTH +: WIDTH];
                    add_b_d   = req_b[i*WIDTH +: WIDTH];
                    add_cin_d = req_cin[i];
                end
            end
            last_d         = grant_idx;
            tag_d[0].valid = 1'b1;
            tag_d[0].id    = grant_idx;
        end

        // The last tag stage lines up with the adder output for that op.
        rsp_valid_d = '0;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        if (tag_q[DEPTH-1].valid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (tag_q[DEPTH-1].id == 3'(i));
            end
            rsp_sum_d  = add_sum;
            rsp_cout_d = add_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            last_q      <= 3'(NUM_REQ - 1);
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            last_q      <= last_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

`ifdef ADDER_ARB_OPCOUNT_EN
    logic [OPCOUNT_W-1:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (xfer && (op_count_q != '1)) begin
            op_count_d = op_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter with a behavioural shared adder (1-cycle pipeline).
module tb_adder_rr_arbiter;
    import adder_arb_pkg::*;

    localparam int W = 5;
    localparam int N = 4;
    localparam int L = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           arb_en = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_cin;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_cin, add_cout;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
`ifdef ADDER_ARB_OPCOUNT_EN
    logic [15:0]    op_count;
`endif

    adder_rr_arbiter #(.WIDTH(W), .NUM_REQ(N), .ADD_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef ADDER_ARB_OPCOUNT_EN
        , .op_count(op_count)
`endif
    );

    always #5 clk = ~clk;

    // Shared adder model, pipelined and reset by the same rst.
    logic [W:0] comb_s, pipe_s;
    assign comb_s = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    always @(posedge clk) begin
        if (rst) pipe_s <= '0;
        else     pipe_s <= comb_s;
    end
    assign {add_cout, add_sum} = (L == 1) ? pipe_s : comb_s;

    // Fixed operands per requester with hand-computed results.
    //   r0: 3+4+0=7       r1: 31+1+0=32 -> 0,c1
    //   r2: 20+15+1=36 -> 4,c1   r3: 17+9+1=27
    logic [W-1:0] exp_sum  [N] = '{5'd7, 5'd0, 5'd4, 5'd27};
    logic         exp_cout [N] = '{1'b0, 1'b1, 1'b1, 1'b0};

    typedef struct {
        int         id;
        int         due;
        logic [W-1:0] sum;
        logic       cout;
    } ent_t;
    ent_t sb[$];

    int cyc = 0;
    int vectors = 0;
    int errors = 0;
    int xfers = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; checks the combinational grant and records the expected response.
    task automatic step(input logic r, input logic en, input logic [N-1:0] v,
                        input logic [N-1:0] exp_rdy, input logic track);
        ent_t e;
        @(negedge clk);
        rst = r; arb_en = en; req_valid = v;
        #1;
        chk("req_ready", int'(req_ready), int'(exp_rdy));
        if (exp_rdy != '0) begin
            xfers++;
            if (track) begin
                for (int i = 0; i < N; i++) begin
                    if (exp_rdy[i]) begin
                        e.id = i; e.due = cyc + 2 + L;
                        e.sum = exp_sum[i]; e.cout = exp_cout[i];
                        sb.push_back(e);
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        ent_t e;
        logic [MAX_REQ-1:0] oh;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            vectors++; errors++;
            $display("FAIL missed_rsp: requester %0d expected in cycle %0d, no rsp_valid pulse arrived", e.id, e.due);
        end
        if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                vectors++; errors++;
                $display("FAIL unexpected_rsp: rsp_valid=%b with nothing pending (cycle %0d)", rsp_valid, cyc);
            end else begin
                e  = sb.pop_front();
                oh = onehot(3'(e.id));
                vectors++;
                if (rsp_valid !== oh[N-1:0] || rsp_sum !== e.sum || rsp_cout !== e.cout || cyc != e.due) begin
                    errors++;
                    $display("FAIL rsp: got valid=%b sum=%0d cout=%0d cycle=%0d, expected valid=%b sum=%0d cout=%0d cycle=%0d",
                             rsp_valid, rsp_sum, rsp_cout, cyc, oh[N-1:0], e.sum, e.cout, e.due);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_a   = {5'd17, 5'd20, 5'd31, 5'd3};
        req_b   = {5'd9,  5'd15, 5'd1,  5'd4};
        req_cin = 4'b1100;

        // Reset held with everyone requesting.
        step(1, 1, 4'b1111, 4'b0000, 0);
        step(1, 1, 4'b1111, 4'b0000, 0);
        xfers = 0;
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_add_a", int'(add_a), 0);
        chk("reset_add_b", int'(add_b), 0);
        chk("reset_add_cin", int'(add_cin), 0);

        // Full contention: 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 4'b1111, 4'(1 << (k % 4)), 1);
        end
        for (int k = 0; k < 5; k++) step(0, 1, 4'b0000, 4'b0000, 0);

        // Single op from requester 2.
        step(0, 1, 4'b0100, 4'b0100, 1);
        for (int k = 0; k < 5; k++) step(0, 1, 4'b0000, 4'b0000, 0);

        // Fairness from last_grant=1, then a lone re-request.
        step(0, 1, 4'b0010, 4'b0010, 1);
        step(0, 1, 4'b1010, 4'b1000, 1);
        step(0, 1, 4'b1010, 4'b0010, 1);
        step(0, 1, 4'b1010, 4'b1000, 1);
        step(0, 1, 4'b1000, 4'b1000, 1);

        // Pause: op issued just before arb_en falls must still return.
        step(0, 1, 4'b0001, 4'b0001, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 4'b0001, 4'b0000, 0);
        step(0, 1, 4'b0001, 4'b0001, 1);
        for (int k = 0; k < 5; k++) step(0, 1, 4'b0000, 4'b0000, 0);

`ifdef ADDER_ARB_OPCOUNT_EN
        chk("op_count", int'(op_count), xfers);
`endif

        // Reset mid-flight: the transfer is discarded.
        step(0, 1, 4'b0100, 4'b0100, 0);
        step(1, 1, 4'b1111, 4'b0000, 0);
        xfers = 0;
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 4'b0000, 4'b0000, 0);
            chk("midrst_rsp_valid", int'(rsp_valid), 0);
        end
        // Pointer is back to NUM_REQ-1, so requester 0 wins.
        step(0, 1, 4'b1111, 4'b0001, 1);
        for (int k = 0; k < 6; k++) step(0, 1, 4'b0000, 4'b0000, 0);

        chk("scoreboard_empty", sb.size(), 0);
`ifdef ADDER_ARB_OPCOUNT_EN
        chk("op_count_final", int'(op_count), xfers);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
